// File: rtl/bp_gateway_watchdog.sv
// Progress watchdog for gateway toplevels: flags a hang when no valid/ready
// handshake completes for a programmable number of cycles (global or per channel).
module bp_gateway_watchdog #(
  parameter int num_chan_p        = 4,
  parameter int cnt_width_p       = 20,
  parameter int default_timeout_p = 100000
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic                   mode_i,
  input  logic [num_chan_p-1:0]  chan_v_i,
  input  logic [num_chan_p-1:0]  chan_ready_i,
  input  logic                   timeout_v_i,
  input  logic [cnt_width_p-1:0] timeout_i,
  input  logic                   finish_i,
  input  logic                   clear_i,
  output logic                   timeout_o,
  output logic [num_chan_p-1:0]  timeout_chan_o,
  output logic                   done_o,
  output logic [cnt_width_p-1:0] idle_cnt_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [cnt_width_p-1:0] cnt_max_lp         = '1;
  localparam logic [cnt_width_p-1:0] cnt_one_lp         = cnt_width_p'(1);
  localparam logic [cnt_width_p-1:0] default_timeout_lp = cnt_width_p'(default_timeout_p);

  state_e                  state_r, state_n;
  logic                    mode_r, mode_n;
  logic [cnt_width_p-1:0]  timeout_r;
  logic [cnt_width_p-1:0]  cnt_r [num_chan_p];
  logic [cnt_width_p-1:0]  cnt_n [num_chan_p];
  logic [num_chan_p-1:0]   tchan_r, tchan_n;
  logic [num_chan_p-1:0]   fire;
  logic [num_chan_p-1:0]   hit;
  logic [cnt_width_p-1:0]  idle_max;

  // A channel fires when valid and ready are both high in the same cycle;
  // the watchdog only observes the handshake and never drives either side.
  assign fire = chan_v_i & chan_ready_i;

  function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v);
    return (v == cnt_max_lp) ? v : v + cnt_one_lp;
  endfunction

  always_comb begin
    state_n = state_r;
    mode_n  = mode_r;
    tchan_n = tchan_r;
    hit     = '0;
    cnt_n   = cnt_r;

    // In global mode counter 0 is the single shared counter; the rest stay 0.
    if (state_r == RUN && en_i) begin
      for (int c = 0; c < num_chan_p; c++) begin
        if (!mode_r) begin
          cnt_n[c] = (c == 0 && fire == '0) ? sat_inc(cnt_r[c]) : '0;
        end else begin
          cnt_n[c] = (chan_v_i[c] && !chan_ready_i[c]) ? sat_inc(cnt_r[c]) : '0;
        end
        hit[c] = (timeout_r != '0) && (cnt_n[c] >= timeout_r);
      end
    end

    case (state_r)
      IDLE: begin
        if (en_i) begin
          state_n = RUN;
          mode_n  = mode_i;
        end
      end
      RUN: begin
        if (finish_i) begin
          state_n = DONE;
        end else if (hit != '0) begin
          state_n = EXPIRED;
          tchan_n = mode_r ? hit : '0;
        end
      end
      default: ;
    endcase

    if (clear_i) begin
      state_n = IDLE;
      tchan_n = '0;
      for (int c = 0; c < num_chan_p; c++) cnt_n[c] = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      mode_r    <= 1'b0;
      timeout_r <= default_timeout_lp;
      tchan_r   <= '0;
      for (int c = 0; c < num_chan_p; c++) cnt_r[c] <= '0;
    end else begin
      state_r <= state_n;
      mode_r  <= mode_n;
      tchan_r <= tchan_n;
      for (int c = 0; c < num_chan_p; c++) cnt_r[c] <= cnt_n[c];
      if (timeout_v_i) timeout_r <= timeout_i;
    end
  end

  always_comb begin
    idle_max = '0;
    for (int c = 0; c < num_chan_p; c++) begin
      if (cnt_r[c] > idle_max) idle_max = cnt_r[c];
    end
  end

  assign idle_cnt_o     = idle_max;
  assign timeout_o      = (state_r == EXPIRED);
  assign done_o         = (state_r == DONE);
  assign timeout_chan_o = tchan_r;
  assign state_o        = state_r;

endmodule

// File: tb/tb_bp_gateway_watchdog.sv
// Bench for bp_gateway_watchdog: vector table, directed corner sequences,
// then randomized traffic against a cycle-level reference model.
module tb_bp_gateway_watchdog;
  localparam int NCH = 4;
  localparam int W   = 20;
  localparam int W4  = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           en, mode, tv, fin, clr;
  logic [NCH-1:0] chv, chr;
  logic [W-1:0]   tin;
  logic           to, done;
  logic [NCH-1:0] tch;
  logic [W-1:0]   idle;
  logic [1:0]     st;

  logic           s_en;
  logic           s_to, s_done;
  logic [NCH-1:0] s_tch;
  logic [W4-1:0]  s_idle;
  logic [1:0]     s_st;

  bp_gateway_watchdog #(.num_chan_p(NCH), .cnt_width_p(W), .default_timeout_p(100000)) dut (
    .clk_i(clk), .reset_i(rst), .en_i(en), .mode_i(mode),
    .chan_v_i(chv), .chan_ready_i(chr), .timeout_v_i(tv), .timeout_i(tin),
    .finish_i(fin), .clear_i(clr),
    .timeout_o(to), .timeout_chan_o(tch), .done_o(done), .idle_cnt_o(idle), .state_o(st)
  );

  bp_gateway_watchdog #(.num_chan_p(NCH), .cnt_width_p(W4), .default_timeout_p(0)) dut_sat (
    .clk_i(clk), .reset_i(rst), .en_i(s_en), .mode_i(1'b0),
    .chan_v_i(4'b0000), .chan_ready_i(4'b0000), .timeout_v_i(1'b0), .timeout_i(4'd0),
    .finish_i(1'b0), .clear_i(1'b0),
    .timeout_o(s_to), .timeout_chan_o(s_tch), .done_o(s_done), .idle_cnt_o(s_idle), .state_o(s_st)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic i_tv, input int i_t, input logic i_en, input logic i_mode,
                        input logic [NCH-1:0] i_v, input logic [NCH-1:0] i_r,
                        input logic i_fin, input logic i_clr);
    tv = i_tv; tin = W'(i_t); en = i_en; mode = i_mode;
    chv = i_v; chr = i_r; fin = i_fin; clr = i_clr;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, '0, '0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // vector table
  typedef struct {
    logic           tv;
    int             t;
    logic           en;
    logic [NCH-1:0] v, r;
    logic           fin, clr;
    int             e_idle;
    logic           e_to, e_done;
    logic [NCH-1:0] e_tch;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic a_tv, input int a_t, input logic a_en,
                              input logic [NCH-1:0] a_v, input logic [NCH-1:0] a_r,
                              input logic a_fin, input logic a_clr,
                              input int e_idle, input logic e_to, input logic e_done);
    vec_t x;
    x.tv = a_tv; x.t = a_t; x.en = a_en; x.v = a_v; x.r = a_r; x.fin = a_fin; x.clr = a_clr;
    x.e_idle = e_idle; x.e_to = e_to; x.e_done = e_done; x.e_tch = '0;
    vecs.push_back(x);
  endfunction

  // reference model: counters as plain integers, one global counter and
  // one per-channel array, evaluated from the behavioural rules
  localparam int M_IDLE = 0, M_RUN = 1, M_EXP = 2, M_DONE = 3;
  int             m_st, m_T, m_g;
  int             m_c [NCH];
  bit             m_mode;
  bit [NCH-1:0]   m_tch;
  logic [W+1+1+NCH-1:0] exp_q[$];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_st = M_IDLE; m_T = 100000; m_g = 0; m_mode = 0; m_tch = '0;
    for (int c = 0; c < NCH; c++) m_c[c] = 0;
  endfunction

  function automatic void model_step();
    int cmax;
    int ng;
    int nc [NCH];
    bit [NCH-1:0] over;
    bit expire;
    cmax = (1 << W) - 1;
    ng = m_g;
    nc = m_c;
    over = '0;
    expire = 0;
    if (m_st == M_RUN && en) begin
      if (!m_mode) begin
        ng = ((chv & chr) != '0) ? 0 : imin(m_g + 1, cmax);
        expire = (m_T != 0) && (ng >= m_T);
      end else begin
        for (int c = 0; c < NCH; c++) begin
          nc[c] = (chv[c] && !chr[c]) ? imin(m_c[c] + 1, cmax) : 0;
          over[c] = (m_T != 0) && (nc[c] >= m_T);
        end
        expire = (over != '0);
      end
    end
    if (clr) begin
      m_st = M_IDLE; m_g = 0; m_tch = '0;
      for (int c = 0; c < NCH; c++) m_c[c] = 0;
    end else if (m_st == M_IDLE) begin
      if (en) begin
        m_st = M_RUN;
        m_mode = mode;
      end
    end else if (m_st == M_RUN) begin
      m_g = ng;
      m_c = nc;
      if (fin) m_st = M_DONE;
      else if (expire) begin
        m_st = M_EXP;
        m_tch = m_mode ? over : '0;
      end
    end
    if (tv) m_T = int'(tin);
  endfunction

  function automatic logic [W+1+1+NCH-1:0] model_out();
    int mx;
    mx = 0;
    if (m_mode) begin
      for (int c = 0; c < NCH; c++) if (m_c[c] > mx) mx = m_c[c];
    end else begin
      mx = m_g;
    end
    return {W'(mx), (m_st == M_EXP), (m_st == M_DONE), m_tch};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got no end of test, required finish before 2ms");
    $fatal(1, "time limit");
  end

  initial begin
    int n_to, mx, bad;
    logic [W+1+1+NCH-1:0] e;
    s_en = 1'b0;
    do_reset();

    // reset state
    check("rst_timeout", 32'(to), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idle", 32'(idle), 32'd0);
    check("rst_tchan", 32'(tch), 32'd0);
    check("rst_state", 32'(st), 32'd0);

    // global T=5 countdown, finish-on-expiry priority, clear keeps T, kick
    add(1, 5, 0, '0, '0, 0, 0, 0, 0, 0);
    add(0, 0, 1, '0, '0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 0, 1, '0, '0, 0, 0, k, (k == 5), 0);
    add(0, 0, 1, '0, '0, 0, 0, 5, 1, 0);
    add(0, 0, 0, '0, '0, 0, 1, 0, 0, 0);
    add(0, 0, 1, '0, '0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(0, 0, 1, '0, '0, 0, 0, k, 0, 0);
    add(0, 0, 1, '0, '0, 1, 0, 5, 0, 1);
    add(0, 0, 0, '0, '0, 0, 0, 5, 0, 1);
    add(0, 0, 0, '0, '0, 0, 1, 0, 0, 0);
    add(0, 0, 1, '0, '0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 0, 1, '0, '0, 0, 0, k, (k == 5), 0);
    add(0, 0, 0, '0, '0, 0, 1, 0, 0, 0);
    add(0, 0, 1, '0, '0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(0, 0, 1, '0, '0, 0, 0, k, 0, 0);
    add(0, 0, 1, 4'b0100, 4'b0100, 0, 0, 0, 0, 0);
    add(0, 0, 1, '0, '0, 0, 0, 1, 0, 0);
    add(0, 0, 0, '0, '0, 0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      set_in(vecs[i].tv, vecs[i].t, vecs[i].en, 1'b0, vecs[i].v, vecs[i].r, vecs[i].fin, vecs[i].clr);
      tick();
      check($sformatf("vec%0d_idle", i), 32'(idle), 32'(vecs[i].e_idle));
      check($sformatf("vec%0d_timeout", i), 32'(to), 32'(vecs[i].e_to));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d_tchan", i), 32'(tch), 32'(vecs[i].e_tch));
    end

    // fire stream every 4 cycles, rotating channel
    set_in(0, 0, 1, 0, '0, '0, 0, 0);
    tick();
    n_to = 0; mx = 0;
    for (int i = 0; i < 1000; i++) begin
      chv = (i % 4 == 3) ? NCH'(1 << ((i / 4) % NCH)) : '0;
      chr = chv;
      tick();
      if (to) n_to++;
      if (int'(idle) > mx) mx = int'(idle);
    end
    check("stream_timeout_cycles", 32'(n_to), 32'd0);
    check("stream_idle_max", 32'(mx), 32'd3);
    set_in(0, 0, 0, 0, '0, '0, 0, 1); tick();

    // per-channel, T=3: ch0/ch3 stall, ch1 alternates
    set_in(1, 3, 0, 1, '0, '0, 0, 0); tick();
    set_in(0, 0, 1, 1, '0, '0, 0, 0); tick();
    for (int s = 0; s < 3; s++) begin
      chv = 4'b1011;
      chr = (s == 1) ? 4'b0010 : 4'b0000;
      tick();
      if (s == 1) check("pc_before_expiry", 32'(to), 32'd0);
    end
    check("pc_timeout", 32'(to), 32'd1);
    check("pc_tchan", 32'(tch), 32'b1001);
    check("pc_idle", 32'(idle), 32'd3);
    set_in(0, 0, 0, 1, '0, '0, 0, 1); tick();
    set_in(0, 0, 1, 1, '0, '0, 0, 0); tick();
    for (int s = 0; s < 3; s++) begin
      chv = (s < 2) ? 4'b1001 : 4'b1000;
      chr = '0;
      tick();
    end
    check("pc_rerun_timeout", 32'(to), 32'd1);
    check("pc_rerun_tchan", 32'(tch), 32'b1000);
    set_in(0, 0, 0, 0, '0, '0, 0, 1); tick();

    // T=0 disables expiry
    set_in(1, 0, 0, 0, '0, '0, 0, 0); tick();
    set_in(0, 0, 1, 0, '0, '0, 0, 0); tick();
    n_to = 0;
    repeat (2000) begin
      tick();
      if (to) n_to++;
    end
    check("t0_timeout_cycles", 32'(n_to), 32'd0);
    check("t0_idle", 32'(idle), 32'd2000);
    set_in(0, 0, 0, 0, '0, '0, 0, 1); tick();

    // lowering T below the live count expires on the following edge
    set_in(0, 0, 1, 0, '0, '0, 0, 0); tick();
    repeat (50) tick();
    check("lower_t_idle50", 32'(idle), 32'd50);
    set_in(1, 10, 1, 0, '0, '0, 0, 0); tick();
    tv = 1'b0;
    check("lower_t_write_edge", 32'(to), 32'd0);
    check("lower_t_write_idle", 32'(idle), 32'd51);
    tick();
    check("lower_t_expired", 32'(to), 32'd1);
    check("lower_t_idle", 32'(idle), 32'd52);
    set_in(0, 0, 0, 0, '0, '0, 0, 1); tick();

    // en_i low freezes counters
    set_in(1, 100, 0, 0, '0, '0, 0, 0); tick();
    set_in(0, 0, 1, 0, '0, '0, 0, 0); tick();
    repeat (5) tick();
    check("freeze_start", 32'(idle), 32'd5);
    en = 1'b0;
    bad = 0;
    repeat (10) begin
      tick();
      if (idle !== W'(5)) bad++;
    end
    check("freeze_cycles_changed", 32'(bad), 32'd0);
    en = 1'b1; tick();
    check("freeze_resume", 32'(idle), 32'd6);
    set_in(0, 0, 0, 0, '0, '0, 0, 1); tick();
    clr = 1'b0;

    // 4-bit counters saturate at 15
    s_en = 1'b1; tick();
    repeat (15) tick();
    check("sat_idle_15", 32'(s_idle), 32'd15);
    repeat (5) tick();
    check("sat_idle_hold", 32'(s_idle), 32'd15);
    check("sat_no_timeout", 32'(s_to), 32'd0);
    s_en = 1'b0;

    // async reset between edges while EXPIRED
    set_in(1, 3, 0, 0, '0, '0, 0, 0); tick();
    set_in(0, 0, 1, 0, '0, '0, 0, 0); tick();
    repeat (3) tick();
    check("arst_pre_timeout", 32'(to), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_timeout", 32'(to), 32'd0);
    check("arst_idle", 32'(idle), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_tchan", 32'(tch), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("arst_state_idle", 32'(st), 32'd0);
    check("arst_default_t", 32'(dut.timeout_r), 32'd100000);

    // randomized traffic against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 99) < 85);
      mode = ($urandom_range(0, 1) == 1);
      for (int c = 0; c < NCH; c++) begin
        chv[c] = ($urandom_range(0, 99) < 75);
        chr[c] = ($urandom_range(0, 99) < 40);
      end
      fin = ($urandom_range(0, 149) == 0);
      clr = ($urandom_range(0, 59) == 0);
      tv  = ($urandom_range(0, 39) == 0);
      tin = W'($urandom_range(0, 8));
      model_step();
      exp_q.push_back(model_out());
      tick();
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_idle", i), 32'(idle), 32'(e[W+1+1+NCH-1 -: W]));
      check($sformatf("rnd%0d_timeout", i), 32'(to), 32'(e[NCH+1]));
      check($sformatf("rnd%0d_done", i), 32'(done), 32'(e[NCH]));
      check($sformatf("rnd%0d_tchan", i), 32'(tch), 32'(e[NCH-1:0]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bp_gateway_watchdog.md
Name: bp_gateway_watchdog

Overview:
- Parametrised progress watchdog for gateway/testbench toplevels. Replaces the fixed free-running cycle-limit counter.
- Monitors num_chan_p valid/ready channels (mem cmd/resp, io cmd/resp, ...) and flags a hang when no progress is seen for a programmable number of cycles.
- Two modes: global (any handshake kicks) and per-channel stall detection. Also has a finish/done path and a software clear.
- Synthesizable, so it can also live on-chip.

Parameters:
- num_chan_p, 4, number of monitored handshake channels (>=1).
- cnt_width_p, 20, width of every idle counter and of the timeout value.
- default_timeout_p, 100000, timeout loaded at reset; must fit in cnt_width_p.

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-high reset.
- en_i  in  1  counting enable; low pauses counters.
- mode_i  in  1  0 = global, 1 = per-channel; latched on IDLE->RUN.
- chan_v_i  in  num_chan_p  channel valid.
- chan_ready_i  in  num_chan_p  channel ready; fire[c] = chan_v_i[c] & chan_ready_i[c].
- timeout_v_i  in  1  load timeout_i into the timeout register.
- timeout_i  in  cnt_width_p  new timeout T; 0 = watchdog disabled.
- finish_i  in  1  program finished.
- clear_i  in  1  return to IDLE, clear counters and sticky flags.
- timeout_o  out  1  sticky hang flag.
- timeout_chan_o  out  num_chan_p  sticky per-channel expiry mask (per-channel mode only).
- done_o  out  1  sticky finish flag.
- idle_cnt_o  out  cnt_width_p  global counter, or max of the per-channel counters.

Behaviour:
- Reset: state IDLE, all counters 0, timeout_r = default_timeout_p, mode_r = 0, all outputs 0. Reset mid-operation aborts immediately with the same values.
- States: IDLE, RUN, EXPIRED, DONE.
  - IDLE->RUN on en_i; mode_r <= mode_i on that edge. Counters stay 0.
  - RUN->EXPIRED on the edge where any active counter becomes >= T (T != 0).
  - RUN->DONE on finish_i.
  - EXPIRED and DONE are terminal until clear_i or reset.
- Priority on the same edge: clear_i > finish_i > expiry.
  - finish_i together with expiry goes to DONE with timeout_o = 0.
  - clear_i from any state goes to IDLE and zeroes counters, timeout_o, timeout_chan_o and done_o. timeout_r is kept.
- Global mode (mode_r = 0): a single counter.
  - Cleared on any fire.
  - Otherwise +1 per RUN cycle with en_i high.
  - Kick wins over reaching T in the same cycle.
  - timeout_chan_o stays 0.
- Per-channel mode (mode_r = 1): counter c behaves as follows.
  - +1 when chan_v_i[c] & ~chan_ready_i[c].
  - Cleared on fire[c] or on chan_v_i[c] low.
  - On expiry, timeout_chan_o[c] = 1 for every c whose next value is >= T; several bits may set together.
- en_i low in RUN: counters hold and no expiry occurs. finish_i and clear_i still act.
- Counters saturate at all-ones and never wrap.
- Timeout update:
  - timeout_v_i writes timeout_r at the clock edge, in any state.
  - The new T is used for comparison from the next cycle; counters are not cleared.
  - If a counter is already >= the new T, expiry occurs on the next RUN edge.
  - T = 0 disables expiry.
- Timing: with no kicks, RUN entered at cycle n gives idle_cnt_o = k at cycle n+k. timeout_o first rises at cycle n+T.
- Outputs are registered or driven from registered state only; no combinational input-to-output path except idle_cnt_o's max over registered counters.
- done_o = (state == DONE). timeout_o = (state == EXPIRED).

Test Plan:
1. Global, T=5 (timeout_v_i at cycle 0), en_i=1 from cycle 1 (RUN at cycle 2), no fires -> idle_cnt_o 1..5 at cycles 3..7; timeout_o=1 from cycle 7; timeout_chan_o=0.
2. Global, T=5, fire on ch2 at the cycle where idle_cnt_o=4 -> counter returns to 0, no expiry; a stream of fires every 4 cycles -> timeout_o stays 0 for 1000 cycles.
3. Per-channel, T=3: ch0 and ch3 held v=1, ready=0 from the same cycle; ch1 alternating fire -> timeout_o=1 and timeout_chan_o=4'b1001 after 3 stall cycles; ch0 v dropped after 2 cycles in a rerun -> ch0 bit stays 0.
4. Edge priority: finish_i on the expiry edge -> done_o=1, timeout_o=0; then clear_i -> IDLE, all flags 0, idle_cnt_o=0, timeout_r still 5.
5. Boundaries: T=0 -> no expiry in 2000 cycles; counter at 50 then T written to 10 -> timeout_o next cycle; cnt_width_p=4, T=0, no fires -> idle_cnt_o saturates at 15; en_i low for 10 cycles -> idle_cnt_o frozen.
6. Async reset asserted mid-RUN between edges -> outputs 0 immediately; after release, timeout_r=default_timeout_p (100000) and state IDLE.
